// File: rtl/button_conditioner_if.sv
// Raw pushbutton/switch inputs and their conditioned versions for the multiplier front end.
// The conditioner is the slave side; whoever drives the raw pins is the master.
interface button_conditioner_if #(
  parameter int SW_WIDTH = 8
);
  logic                run_raw;
  logic                clr_raw;
  logic [SW_WIDTH-1:0] sw_raw;
  logic                run_pulse;
  logic                clr_pulse;
  logic                clr_level;
  logic [SW_WIDTH-1:0] sw_sync;

  modport master (
    output run_raw, clr_raw, sw_raw,
    input  run_pulse, clr_pulse, clr_level, sw_sync
  );

  modport slave (
    input  run_raw, clr_raw, sw_raw,
    output run_pulse, clr_pulse, clr_level, sw_sync
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces the Run and Reset_Load_Clr buttons.
// Also synchronises the switch bus feeding the Lab 4 multiplier.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int SW_WIDTH        = 8
) (
  input logic                 Clk,
  input logic                 Reset_n,
  button_conditioner_if.slave bus
);
  localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SYNC_W = SW_WIDTH + 2;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  // Buttons and switches share one synchroniser chain: bit 0 run, bit 1 clear, rest switches.
  logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
  logic [SYNC_W-1:0] synced;
  logic [1:0]        pulse_all;
  logic [1:0]        level_all;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus.sw_raw, bus.clr_raw, bus.run_raw};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  for (genvar b = 0; b < 2; b++) begin : g_btn
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          pulse_q, level_q, pulse_d, level_d;
    logic          btn;

    assign btn = synced[b];

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state   <= IDLE;
        cnt     <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state   <= state_next;
        cnt     <= cnt_next;
        pulse_q <= pulse_d;
        level_q <= level_d;
      end
    end

    // cnt holds the number of consecutive samples already seen that disagree with the accepted level.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
        IDLE: begin
          if (!btn) begin
            cnt_next = '0;
          end else if (DEBOUNCE_CYCLES == 1) begin
            state_next = HELD;
            cnt_next   = '0;
          end else begin
            state_next = PRESS_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!btn) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = HELD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn && DEBOUNCE_CYCLES == 1) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (!btn) begin
            state_next = RELEASE_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (btn) begin
            state_next = HELD;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    // A bounce back into HELD from RELEASE_WAIT must not re-fire the pulse.
    always_comb begin
      pulse_d = (state == IDLE || state == PRESS_WAIT) && (state_next == HELD);
      level_d = (state_next == HELD) || (state_next == RELEASE_WAIT);
    end

    assign pulse_all[b] = pulse_q;
    assign level_all[b] = level_q;
  end

  assign bus.run_pulse = pulse_all[0];
  assign bus.clr_pulse = pulse_all[1];
  assign bus.clr_level = level_all[1];
  assign bus.sw_sync   = synced[SYNC_W-1:2];
endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// A run-length debounce model is compared every cycle, alongside hand-computed directed checks.
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int SWW  = 8;

  logic clk;
  logic rst_n;
  logic compare_en;
  int   checks;
  int   errors;

  logic           exp_run_pulse;
  logic           exp_clr_pulse;
  logic           exp_clr_level;
  logic [SWW-1:0] exp_sw;

  button_conditioner_if #(.SW_WIDTH(SWW)) bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC),
    .SW_WIDTH       (SWW)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic clr, input logic [SWW-1:0] sw, input int edges);
    bus.run_raw = run;
    bus.clr_raw = clr;
    bus.sw_raw  = sw;
    repeat (edges) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A button's accepted level flips once DEB consecutive synced samples disagree with it.
  always @(posedge clk or negedge rst_n) begin : model
    logic [SWW+1:0] pipe [SYNC];
    int             run_len [2];
    logic           acc [2];
    logic           pulse [2];
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        run_len[b] = 0;
        acc[b]     = 1'b0;
        pulse[b]   = 1'b0;
      end
      for (int i = 0; i < SYNC; i++) pipe[i] = '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        pulse[b] = 1'b0;
        if (pipe[SYNC-1][b] != acc[b]) begin
          run_len[b] = run_len[b] + 1;
          if (run_len[b] == DEB) begin
            acc[b]     = pipe[SYNC-1][b];
            run_len[b] = 0;
            pulse[b]   = acc[b];
          end
        end else begin
          run_len[b] = 0;
        end
      end
      for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = {bus.sw_raw, bus.clr_raw, bus.run_raw};
    end
    exp_run_pulse <= pulse[0];
    exp_clr_pulse <= pulse[1];
    exp_clr_level <= acc[1];
    exp_sw        <= pipe[SYNC-1][SWW+1:2];
  end

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("cmp_run_pulse", 32'(bus.run_pulse), 32'(exp_run_pulse));
      checkOutput("cmp_clr_pulse", 32'(bus.clr_pulse), 32'(exp_clr_pulse));
      checkOutput("cmp_clr_level", 32'(bus.clr_level), 32'(exp_clr_level));
      checkOutput("cmp_sw_sync",   32'(bus.sw_sync),   32'(exp_sw));
    end
  end

  initial begin
    logic bounce [7];
    bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    checks      = 0;
    errors      = 0;
    compare_en  = 1'b0;
    rst_n       = 1'b0;
    bus.run_raw = 1'b0;
    bus.clr_raw = 1'b0;
    bus.sw_raw  = '0;
    applyStimulus(1'b1, 1'b1, 8'hFF, 3);
    checkOutput("reset_run_pulse", 32'(bus.run_pulse), 32'd0);
    checkOutput("reset_clr_pulse", 32'(bus.clr_pulse), 32'd0);
    checkOutput("reset_clr_level", 32'(bus.clr_level), 32'd0);
    checkOutput("reset_sw_sync",   32'(bus.sw_sync),   32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    compare_en = 1'b1;
    rst_n      = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 3);

    $display("[TB] switch synchroniser latency");
    applyStimulus(1'b0, 1'b0, 8'hA5, 1);
    checkOutput("sw_a5_edge0", 32'(bus.sw_sync), 32'h00);
    applyStimulus(1'b0, 1'b0, 8'hA5, 1);
    checkOutput("sw_a5_edge1", 32'(bus.sw_sync), 32'hA5);
    applyStimulus(1'b0, 1'b0, 8'h3C, 1);
    checkOutput("sw_3c_edge0", 32'(bus.sw_sync), 32'hA5);
    applyStimulus(1'b0, 1'b0, 8'h3C, 1);
    checkOutput("sw_3c_edge1", 32'(bus.sw_sync), 32'h3C);

    $display("[TB] clean run press");
    applyStimulus(1'b1, 1'b0, 8'h3C, 5);
    checkOutput("press_before", 32'(bus.run_pulse), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1);
    checkOutput("press_pulse", 32'(bus.run_pulse), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1);
    checkOutput("press_after", 32'(bus.run_pulse), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h3C, 10);
    checkOutput("press_held", 32'(bus.run_pulse), 32'd0);
    checkOutput("press_clr_idle", 32'(bus.clr_level), 32'd0);

    $display("[TB] release glitch then re-press");
    applyStimulus(1'b0, 1'b0, 8'h3C, 2);
    applyStimulus(1'b1, 1'b0, 8'h3C, 8);
    checkOutput("glitch_no_pulse", 32'(bus.run_pulse), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h3C, 8);
    applyStimulus(1'b1, 1'b0, 8'h3C, 5);
    checkOutput("repress_before", 32'(bus.run_pulse), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1);
    checkOutput("repress_pulse", 32'(bus.run_pulse), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h3C, 8);

    $display("[TB] bouncy press");
    for (int i = 0; i < 7; i++) applyStimulus(bounce[i], 1'b0, 8'h3C, 1);
    checkOutput("bounce_edge6", 32'(bus.run_pulse), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1);
    checkOutput("bounce_edge7", 32'(bus.run_pulse), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1);
    checkOutput("bounce_pulse", 32'(bus.run_pulse), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1);
    checkOutput("bounce_after", 32'(bus.run_pulse), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h3C, 8);

    $display("[TB] simultaneous run and clear");
    applyStimulus(1'b1, 1'b1, 8'h3C, 5);
    checkOutput("both_run_before", 32'(bus.run_pulse), 32'd0);
    checkOutput("both_clr_before", 32'(bus.clr_pulse), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'h3C, 1);
    checkOutput("both_run_pulse", 32'(bus.run_pulse), 32'd1);
    checkOutput("both_clr_pulse", 32'(bus.clr_pulse), 32'd1);
    checkOutput("both_clr_level", 32'(bus.clr_level), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h3C, 5);
    checkOutput("clr_level_hold", 32'(bus.clr_level), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h3C, 1);
    checkOutput("clr_level_fall", 32'(bus.clr_level), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h3C, 3);

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(1'b0, 1'b1, 8'h3C, 10);
    checkOutput("pre_reset_level", 32'(bus.clr_level), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h3C, 3);
    rst_n = 1'b0;
    #2;
    checkOutput("async_run_pulse", 32'(bus.run_pulse), 32'd0);
    checkOutput("async_clr_pulse", 32'(bus.clr_pulse), 32'd0);
    checkOutput("async_clr_level", 32'(bus.clr_level), 32'd0);
    checkOutput("async_sw_sync",   32'(bus.sw_sync),   32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h3C, 5);
    checkOutput("recount_before", 32'(bus.run_pulse), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'h3C, 1);
    checkOutput("recount_run_pulse", 32'(bus.run_pulse), 32'd1);
    checkOutput("recount_clr_pulse", 32'(bus.clr_pulse), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 10);

    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
